// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared encodings, FSM states and constants for alu_staged.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int unsigned DEF_TIMEOUT = 16;

   // Arithmetic commands (MODE = 1)
   localparam logic [3:0] A_ADD     = 4'd0;
   localparam logic [3:0] A_SUB     = 4'd1;
   localparam logic [3:0] A_ADD_CIN = 4'd2;
   localparam logic [3:0] A_SUB_CIN = 4'd3;
   localparam logic [3:0] A_INC_A   = 4'd4;
   localparam logic [3:0] A_DEC_A   = 4'd5;
   localparam logic [3:0] A_INC_B   = 4'd6;
   localparam logic [3:0] A_DEC_B   = 4'd7;
   localparam logic [3:0] A_CMP     = 4'd8;
   localparam logic [3:0] A_MUL_INC = 4'd9;
   localparam logic [3:0] A_MUL_SHL = 4'd10;
   localparam logic [3:0] A_SADD    = 4'd11;
   localparam logic [3:0] A_SSUB    = 4'd12;

   // Logic commands (MODE = 0)
   localparam logic [3:0] L_AND     = 4'd0;
   localparam logic [3:0] L_NAND    = 4'd1;
   localparam logic [3:0] L_OR      = 4'd2;
   localparam logic [3:0] L_NOR     = 4'd3;
   localparam logic [3:0] L_XOR     = 4'd4;
   localparam logic [3:0] L_XNOR    = 4'd5;
   localparam logic [3:0] L_NOT_A   = 4'd6;
   localparam logic [3:0] L_NOT_B   = 4'd7;
   localparam logic [3:0] L_SHR1_A  = 4'd8;
   localparam logic [3:0] L_SHL1_A  = 4'd9;
   localparam logic [3:0] L_SHR1_B  = 4'd10;
   localparam logic [3:0] L_SHL1_B  = 4'd11;
   localparam logic [3:0] L_ROL     = 4'd12;
   localparam logic [3:0] L_ROR     = 4'd13;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_A = 3'd1,
      WAIT_B = 3'd2,
      EXEC   = 3'd3,
      MUL2   = 3'd4
   } state_t;

   typedef struct packed {
      logic cout;
      logic oflow;
      logic g;
      logic e;
      logic l;
      logic err;
   } flags_t;

   localparam flags_t ERR_FLAGS = '{cout: 1'b0, oflow: 1'b0, g: 1'b0,
                                    e: 1'b0, l: 1'b0, err: 1'b1};

   // Operand-valid bits an op needs: 01 = A only, 10 = B only, 00 = none (illegal op).
   function automatic logic [1:0] need_mask(input logic mode, input logic [3:0] cmd);
      logic [1:0] m;
      m = 2'b11;
      if (mode) begin
         if (cmd == A_INC_A || cmd == A_DEC_A)      m = 2'b01;
         else if (cmd == A_INC_B || cmd == A_DEC_B) m = 2'b10;
         else if (cmd > A_SSUB)                     m = 2'b00;
      end else begin
         if (cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A)      m = 2'b01;
         else if (cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B) m = 2'b10;
         else if (cmd > L_ROR)                                          m = 2'b00;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul2.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul2
// Brief    : Two-stage registered N x N -> 2N multiplier with valid pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul2 #(
   parameter int N = 8
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           i_ce,
   input  logic           i_valid,
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_product,
   output logic           o_valid
);

   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic           r_v1;
   logic [2*N-1:0] r_p;
   logic           r_v2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_a  <= '0;
         r_b  <= '0;
         r_v1 <= 1'b0;
         r_p  <= '0;
         r_v2 <= 1'b0;
      end else if (i_ce) begin
         r_a  <= i_a;
         r_b  <= i_b;
         r_v1 <= i_valid;
         r_p  <= {{N{1'b0}}, r_a} * {{N{1'b0}}, r_b};
         r_v2 <= r_v1;
      end
   end

   assign o_product = r_p;
   assign o_valid   = r_v2;

endmodule
`default_nettype wire

// File: rtl/alu_staged.sv
`default_nettype none
// ============================================================================
// Module   : alu_staged
// Brief    : N-bit ALU with operand staging, timeout, pipelined multiply.
//            Define ALU_SAT_EN to saturate SADD/SSUB instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module alu_staged
   import alu_pkg::*;
#(
   parameter int N       = 8,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CE,
   input  logic           MODE,
   input  logic [3:0]     CMD,
   input  logic [1:0]     INP_VALID,
   input  logic [N-1:0]   OPA,
   input  logic [N-1:0]   OPB,
   input  logic           CIN,
   output logic [2*N-1:0] RES,
   output logic           COUT,
   output logic           OFLOW,
   output logic           G,
   output logic           E,
   output logic           L,
   output logic           ERR,
   output logic           RES_VALID,
   output logic           BUSY
);

   localparam int            c_sw     = $clog2(N);
   localparam int            c_cw     = $clog2(TIMEOUT + 1);
   localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT - 1);
   localparam logic [c_cw-1:0] c_cinc = c_cw'(1);
   localparam logic [N-1:0]  c_one_n  = N'(1);
   localparam logic [N:0]    c_one_w  = {{N{1'b0}}, 1'b1};

   state_t           r_state, w_next;
   logic [N-1:0]     r_a, r_b, w_a_sel, w_b_sel, w_mul_a, w_mul_b;
   logic [3:0]       r_cmd, w_cmd_sel;
   logic             r_mode, w_mode_sel, r_cin, w_cin_sel;
   logic [c_cw-1:0]  r_cnt;
   logic [1:0]       w_need, w_missing;
   logic             w_in_idle, w_in_wait, w_is_mul, w_arrive, w_timeout;
   logic             w_latch, w_go_mul, w_done, w_mul_vld;
   logic [2*N-1:0]   w_mul_p;
   logic [2*N-1:0]   r_res, w_res_nxt, w_core_res;
   flags_t           r_flags, w_flags_nxt, w_core_flags;
   logic             r_res_valid;
   logic [N:0]       w_sum, w_ssum;
   logic [2*N-1:0]   w_rot;
   logic [N-1:0]     w_lres;
   logic [c_sw-1:0]  w_amt;
`ifdef ALU_SAT_EN
   logic [N-1:0]     w_sat;
`endif

   // Operands/command seen this cycle: live inputs for whatever is still outstanding.
   always_comb begin
      w_in_idle  = (r_state == IDLE);
      w_in_wait  = (r_state == WAIT_A) || (r_state == WAIT_B);
      w_a_sel    = (w_in_idle || r_state == WAIT_A) ? OPA : r_a;
      w_b_sel    = (w_in_idle || r_state == WAIT_B) ? OPB : r_b;
      w_cmd_sel  = w_in_idle ? CMD  : r_cmd;
      w_mode_sel = w_in_idle ? MODE : r_mode;
      w_cin_sel  = w_in_idle ? CIN  : r_cin;
      w_need     = need_mask(w_mode_sel, w_cmd_sel);
      w_missing  = w_need & ~INP_VALID;
      w_is_mul   = w_mode_sel && (w_cmd_sel == A_MUL_INC || w_cmd_sel == A_MUL_SHL);
      w_arrive   = (r_state == WAIT_A && INP_VALID[0]) || (r_state == WAIT_B && INP_VALID[1]);
      w_timeout  = w_in_wait && !w_arrive && (r_cnt == c_last);
      w_latch    = (w_in_idle && INP_VALID != 2'b00) || w_arrive;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (INP_VALID != 2'b00) begin
               if (w_missing == 2'b00) w_next = w_is_mul ? MUL2 : EXEC;
               else if (w_missing[0])  w_next = WAIT_A;
               else                    w_next = WAIT_B;
            end
         end
         WAIT_A, WAIT_B: begin
            if (w_arrive)       w_next = w_is_mul ? MUL2 : EXEC;
            else if (w_timeout) w_next = IDLE;
         end
         EXEC:    w_next = IDLE;
         MUL2:    if (w_mul_vld) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The multiplier captures on the same edge the operands are latched.
   always_comb begin
      w_go_mul = (w_next == MUL2) && (r_state != MUL2);
      w_mul_a  = (w_cmd_sel == A_MUL_INC) ? w_a_sel + c_one_n : {w_a_sel[N-2:0], 1'b0};
      w_mul_b  = (w_cmd_sel == A_MUL_INC) ? w_b_sel + c_one_n : w_b_sel;
      w_done   = (r_state == EXEC) || (r_state == MUL2 && w_mul_vld) || w_timeout;
   end

   alu_mul2 #(.N(N)) u_mul2 (
      .CLK       (CLK),
      .RST       (RST),
      .i_ce      (CE),
      .i_valid   (w_go_mul),
      .i_a       (w_mul_a),
      .i_b       (w_mul_b),
      .o_product (w_mul_p),
      .o_valid   (w_mul_vld)
   );

   always_comb begin
      w_core_res   = '0;
      w_core_flags = '0;
      w_sum        = '0;
      w_ssum       = '0;
      w_rot        = '0;
      w_lres       = '0;
      w_amt        = r_b[c_sw-1:0];
`ifdef ALU_SAT_EN
      w_sat        = '0;
`endif
      if (r_mode) begin
         case (r_cmd)
            A_ADD, A_ADD_CIN, A_INC_A, A_INC_B: begin
               if (r_cmd == A_ADD)          w_sum = {1'b0, r_a} + {1'b0, r_b};
               else if (r_cmd == A_ADD_CIN) w_sum = {1'b0, r_a} + {1'b0, r_b} + {{N{1'b0}}, r_cin};
               else if (r_cmd == A_INC_A)   w_sum = {1'b0, r_a} + c_one_w;
               else                         w_sum = {1'b0, r_b} + c_one_w;
               w_core_res        = {{(N-1){1'b0}}, w_sum};
               w_core_flags.cout = w_sum[N];
            end
            A_SUB, A_SUB_CIN, A_DEC_A, A_DEC_B: begin
               // Bit N of the (N+1)-bit difference is the borrow.
               if (r_cmd == A_SUB)          w_sum = {1'b0, r_a} - {1'b0, r_b};
               else if (r_cmd == A_SUB_CIN) w_sum = {1'b0, r_a} - {1'b0, r_b} - {{N{1'b0}}, r_cin};
               else if (r_cmd == A_DEC_A)   w_sum = {1'b0, r_a} - c_one_w;
               else                         w_sum = {1'b0, r_b} - c_one_w;
               w_core_res         = {{N{1'b0}}, w_sum[N-1:0]};
               w_core_flags.oflow = w_sum[N];
            end
            A_CMP: begin
               w_core_flags.g = (r_a > r_b);
               w_core_flags.e = (r_a == r_b);
               w_core_flags.l = (r_a < r_b);
            end
            A_MUL_INC, A_MUL_SHL: ;
            A_SADD, A_SSUB: begin
               if (r_cmd == A_SADD) w_ssum = {r_a[N-1], r_a} + {r_b[N-1], r_b};
               else                 w_ssum = {r_a[N-1], r_a} - {r_b[N-1], r_b};
               w_core_flags.oflow = w_ssum[N] ^ w_ssum[N-1];
               w_core_flags.g     = ($signed(r_a) > $signed(r_b));
               w_core_flags.e     = (r_a == r_b);
               w_core_flags.l     = ($signed(r_a) < $signed(r_b));
`ifdef ALU_SAT_EN
               if (w_core_flags.oflow) begin
                  w_sat      = w_ssum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                  w_core_res = {{N{w_sat[N-1]}}, w_sat};
               end else begin
                  w_core_res = {{(N-1){w_ssum[N]}}, w_ssum};
               end
`else
               w_core_res = {{(N-1){w_ssum[N]}}, w_ssum};
`endif
            end
            default: w_core_flags.err = 1'b1;
         endcase
      end else begin
         case (r_cmd)
            L_AND:    w_lres = r_a & r_b;
            L_NAND:   w_lres = ~(r_a & r_b);
            L_OR:     w_lres = r_a | r_b;
            L_NOR:    w_lres = ~(r_a | r_b);
            L_XOR:    w_lres = r_a ^ r_b;
            L_XNOR:   w_lres = ~(r_a ^ r_b);
            L_NOT_A:  w_lres = ~r_a;
            L_NOT_B:  w_lres = ~r_b;
            L_SHR1_A: w_lres = {1'b0, r_a[N-1:1]};
            L_SHL1_A: w_lres = {r_a[N-2:0], 1'b0};
            L_SHR1_B: w_lres = {1'b0, r_b[N-1:1]};
            L_SHL1_B: w_lres = {r_b[N-2:0], 1'b0};
            L_ROL: begin
               w_rot            = {r_a, r_a} << w_amt;
               w_lres           = w_rot[2*N-1:N];
               w_core_flags.err = ((r_b >> c_sw) != '0);
            end
            L_ROR: begin
               w_rot            = {r_a, r_a} >> w_amt;
               w_lres           = w_rot[N-1:0];
               w_core_flags.err = ((r_b >> c_sw) != '0);
            end
            default: w_core_flags.err = 1'b1;
         endcase
         w_core_res = {{N{1'b0}}, w_lres};
      end
   end

   always_comb begin
      w_res_nxt   = w_core_res;
      w_flags_nxt = w_core_flags;
      if (w_timeout) begin
         w_res_nxt   = '0;
         w_flags_nxt = ERR_FLAGS;
      end else if (r_state == MUL2) begin
         w_res_nxt   = w_mul_p;
         w_flags_nxt = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_cmd       <= '0;
         r_mode      <= 1'b0;
         r_cin       <= 1'b0;
         r_res       <= '0;
         r_flags     <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= CE && w_done;
         if (CE) begin
            r_state <= w_next;
            if (w_latch) begin
               r_a    <= w_a_sel;
               r_b    <= w_b_sel;
               r_cmd  <= w_cmd_sel;
               r_mode <= w_mode_sel;
               r_cin  <= w_cin_sel;
            end
            if (w_in_wait && !w_arrive && !w_timeout) r_cnt <= r_cnt + c_cinc;
            else                                      r_cnt <= '0;
            if (w_done) begin
               r_res   <= w_res_nxt;
               r_flags <= w_flags_nxt;
            end
         end
      end
   end

   assign RES       = r_res;
   assign COUT      = r_flags.cout;
   assign OFLOW     = r_flags.oflow;
   assign G         = r_flags.g;
   assign E         = r_flags.e;
   assign L         = r_flags.l;
   assign ERR       = r_flags.err;
   assign RES_VALID = r_res_valid;
   assign BUSY      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_staged.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_staged
// Brief    : Directed self-checking bench for alu_staged (N=8, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_staged;

   logic        CLK, RST, CE, MODE, CIN;
   logic [3:0]  CMD;
   logic [1:0]  INP_VALID;
   logic [7:0]  OPA, OPB;
   logic [15:0] RES;
   logic        COUT, OFLOW, G, E, L, ERR, RES_VALID, BUSY;

   int n_vec = 0;
   int n_err = 0;

   alu_staged #(.N(8), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
      .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
      .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L),
      .ERR(ERR), .RES_VALID(RES_VALID), .BUSY(BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one command for a single cycle, then drop INP_VALID.
   task automatic issue(input logic m, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] v);
      MODE = m; CMD = c; OPA = a; OPB = b; INP_VALID = v;
      step();
      INP_VALID = 2'b00;
   endtask

   task automatic chk_flags(input string tag, input logic [5:0] exp);
      chk(tag, {26'd0, COUT, OFLOW, G, E, L, ERR}, {26'd0, exp});
   endtask

   initial begin
      RST = 1'b1; CE = 1'b1; MODE = 1'b0; CMD = 4'd0; INP_VALID = 2'b00;
      OPA = 8'h00; OPB = 8'h00; CIN = 1'b0;
      step(); step();
      chk("reset_res", RES, 16'h0000);
      chk_flags("reset_flags", 6'b000000);
      chk("reset_rv", RES_VALID, 1'b0);
      chk("reset_busy", BUSY, 1'b0);
      RST = 1'b0;
      step();

      // ADD FF+01
      issue(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11);
      chk("add_busy", BUSY, 1'b1);
      chk("add_rv_early", RES_VALID, 1'b0);
      step();
      chk("add_res", RES, 16'h0100);
      chk_flags("add_flags", 6'b100000);
      chk("add_rv", RES_VALID, 1'b1);
      chk("add_busy_after", BUSY, 1'b0);
      step();
      chk("add_rv_pulse", RES_VALID, 1'b0);
      chk("add_res_held", RES, 16'h0100);

      // Split operands: SUB 5-7, B arrives three cycles after A
      issue(1'b1, 4'd1, 8'h05, 8'hAA, 2'b01);
      chk("split_busy1", BUSY, 1'b1);
      CMD = 4'd0; OPA = 8'h33;
      step();
      chk("split_busy2", BUSY, 1'b1);
      step();
      chk("split_busy3", BUSY, 1'b1);
      chk("split_rv_wait", RES_VALID, 1'b0);
      OPB = 8'h07; INP_VALID = 2'b10;
      step();
      INP_VALID = 2'b00;
      chk("split_busy4", BUSY, 1'b1);
      step();
      chk("split_res", RES, 16'h00FE);
      chk_flags("split_flags", 6'b010000);
      chk("split_rv", RES_VALID, 1'b1);
      chk("split_busy_after", BUSY, 1'b0);

      // Timeout: A only, then nothing for 16 cycles
      issue(1'b1, 4'd0, 8'h11, 8'h22, 2'b01);
      for (int i = 0; i < 15; i++) step();
      chk("to_busy_last", BUSY, 1'b1);
      chk("to_rv_before", RES_VALID, 1'b0);
      step();
      chk("to_res", RES, 16'h0000);
      chk_flags("to_flags", 6'b000001);
      chk("to_rv", RES_VALID, 1'b1);
      chk("to_idle", BUSY, 1'b0);
      step();
      chk("to_rv_pulse", RES_VALID, 1'b0);

      // MUL_INC (3+1)*(4+1)
      issue(1'b1, 4'd9, 8'd3, 8'd4, 2'b11);
      step();
      chk("mul_rv_early", RES_VALID, 1'b0);
      chk("mul_busy", BUSY, 1'b1);
      step();
      chk("mul_res", RES, 16'h0014);
      chk_flags("mul_flags", 6'b000000);
      chk("mul_rv", RES_VALID, 1'b1);
      step();

      // MUL_INC (5+1)*(6+1) with CE low for two cycles mid-operation
      issue(1'b1, 4'd9, 8'd5, 8'd6, 2'b11);
      CE = 1'b0;
      step();
      chk("mulce_frozen_rv1", RES_VALID, 1'b0);
      step();
      chk("mulce_frozen_rv2", RES_VALID, 1'b0);
      chk("mulce_frozen_res", RES, 16'h0014);
      chk("mulce_frozen_busy", BUSY, 1'b1);
      CE = 1'b1;
      step();
      chk("mulce_rv_early", RES_VALID, 1'b0);
      step();
      chk("mulce_res", RES, 16'h002A);
      chk("mulce_rv", RES_VALID, 1'b1);

      // MUL_SHL (0x41<<1 mod 256)*3 = 0x82*3
      issue(1'b1, 4'd10, 8'h41, 8'h03, 2'b11);
      step(); step();
      chk("mulshl_res", RES, 16'h0186);

      // Single-operand ops need only their own valid bit
      issue(1'b1, 4'd4, 8'hFF, 8'h00, 2'b01);
      step();
      chk("inca_res", RES, 16'h0100);
      chk_flags("inca_flags", 6'b100000);
      issue(1'b1, 4'd7, 8'h00, 8'h00, 2'b10);
      step();
      chk("decb_res", RES, 16'h00FF);
      chk_flags("decb_flags", 6'b010000);

      // ADD+CIN and SUB-CIN
      CIN = 1'b1;
      issue(1'b1, 4'd2, 8'h80, 8'h7F, 2'b11);
      step();
      chk("addc_res", RES, 16'h0100);
      issue(1'b1, 4'd3, 8'h05, 8'h05, 2'b11);
      step();
      chk("subc_res", RES, 16'h00FF);
      chk_flags("subc_flags", 6'b010000);
      CIN = 1'b0;

      // CMP
      issue(1'b1, 4'd8, 8'h05, 8'h05, 2'b11);
      step();
      chk("cmp_eq_res", RES, 16'h0000);
      chk_flags("cmp_eq", 6'b000100);
      issue(1'b1, 4'd8, 8'h03, 8'h09, 2'b11);
      step();
      chk_flags("cmp_lt", 6'b000010);

      // Signed ADD/SUB overflow cases
      issue(1'b1, 4'd11, 8'h7F, 8'h01, 2'b11);
      step();
`ifdef ALU_SAT_EN
      chk("sadd_res", RES, 16'h007F);
`else
      chk("sadd_res", RES, 16'h0080);
`endif
      chk_flags("sadd_flags", 6'b011000);
      issue(1'b1, 4'd12, 8'h80, 8'h01, 2'b11);
      step();
`ifdef ALU_SAT_EN
      chk("ssub_res", RES, 16'hFF80);
`else
      chk("ssub_res", RES, 16'hFF7F);
`endif
      chk_flags("ssub_flags", 6'b010010);
      issue(1'b1, 4'd11, 8'hFE, 8'h01, 2'b11);
      step();
      chk("sadd_neg_res", RES, 16'hFFFF);
      chk_flags("sadd_neg_flags", 6'b000010);

      // Illegal arithmetic command
      issue(1'b1, 4'd14, 8'h01, 8'h01, 2'b11);
      step();
      chk_flags("arith_illegal", 6'b000001);

      // Logic ops
      issue(1'b0, 4'd1, 8'hF0, 8'h3C, 2'b11);
      step();
      chk("nand_res", RES, 16'h00CF);
      chk_flags("nand_flags", 6'b000000);
      issue(1'b0, 4'd11, 8'h00, 8'hC3, 2'b10);
      step();
      chk("shl1b_res", RES, 16'h0086);

      // Rotates
      issue(1'b0, 4'd12, 8'h81, 8'h09, 2'b11);
      step();
      chk("rol_hi_res", RES, 16'h0003);
      chk("rol_hi_err", ERR, 1'b1);
      issue(1'b0, 4'd12, 8'h81, 8'h01, 2'b11);
      step();
      chk("rol_res", RES, 16'h0003);
      chk("rol_err", ERR, 1'b0);
      issue(1'b0, 4'd13, 8'h81, 8'h02, 2'b11);
      step();
      chk("ror_res", RES, 16'h0060);

      // Asynchronous reset while waiting for B
      issue(1'b1, 4'd0, 8'h01, 8'h00, 2'b01);
      chk("rst_wait_busy", BUSY, 1'b1);
      #3 RST = 1'b1;
      #1;
      chk("rst_async_res", RES, 16'h0000);
      chk("rst_async_busy", BUSY, 1'b0);
      chk_flags("rst_async_flags", 6'b000000);
      #2 RST = 1'b0;
      step();
      issue(1'b1, 4'd0, 8'h01, 8'h01, 2'b11);
      step();
      chk("post_rst_add", RES, 16'h0002);
      chk("post_rst_rv", RES_VALID, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_staged.md
Name: alu_staged

Overview:
- Parametrised N-bit successor to the 8-bit ALU.
- Adds operand staging: OPA and OPB may arrive in different cycles, and a missing operand has a bounded wait.
- Adds a result-valid/busy handshake, a 2-cycle pipelined multiply path and signed arithmetic.
- Sits between the operand-issue logic and the result writeback; outputs are registered.

Parameters:
- N, 8: operand width in bits; RES is 2N bits wide.
- TIMEOUT, 16: cycles allowed for the missing operand to arrive before an error result is issued.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; 0 freezes all state.
- MODE  in  1  1 = arithmetic, 0 = logic.
- CMD  in  4  operation code.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- OPA  in  N  operand A.
- OPB  in  N  operand B.
- CIN  in  1  carry-in.
- RES  out  2N  result.
- COUT  out  1  carry-out.
- OFLOW  out  1  borrow / overflow.
- G  out  1  greater-than flag.
- E  out  1  equal flag.
- L  out  1  less-than flag.
- ERR  out  1  error flag.
- RES_VALID  out  1  one-cycle pulse marking a new result.
- BUSY  out  1  high while an operation is in flight.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; timeout counter cleared. Takes effect immediately, including mid-operation.
- FSM states: IDLE, WAIT_A, WAIT_B, EXEC, MUL2.
- IDLE, two-operand op:
  - INP_VALID=11: latch both operands, go to EXEC (or MUL2 for multiply).
  - INP_VALID=01: latch OPA, CMD, MODE, CIN; go to WAIT_B.
  - INP_VALID=10: latch OPB, CMD, MODE, CIN; go to WAIT_A.
- IDLE, single-operand op (INC/DEC/NOT/SHIFT): needs only its own operand bit in INP_VALID.
- IDLE, INP_VALID=00: no action.
- WAIT_x:
  - Counter increments each CE cycle.
  - When the missing INP_VALID bit is seen, latch that operand and go to EXEC/MUL2. All other inputs are ignored.
  - After TIMEOUT cycles without it: issue ERR=1, RES=0, clear all other flags, pulse RES_VALID, return to IDLE.
- Latency, counted from the cycle in which all operands are held:
  - 1 cycle for normal ops.
  - 2 cycles for multiply (alu_mul2 stage).
- Outputs stay held until the next result. RES_VALID pulses for exactly one cycle per result.
- BUSY is 1 in WAIT_A, WAIT_B, EXEC and MUL2. New commands are accepted only in IDLE.
- CE=0: all registers hold and RES_VALID is forced 0. A pending result is issued on the first cycle CE returns to 1.
- Arithmetic ops (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD+CIN, 3 SUB−CIN.
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP.
  - 9 MUL_INC = (A+1)*(B+1).
  - 10 MUL_SHL = (A<<1 mod 2^N)*B.
  - 11 SADD, 12 SSUB (signed).
  - 13–15: ERR=1.
- Logic ops (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL A by B, 13 ROR A by B.
  - 14–15: ERR=1.
- Result and flag width rules:
  - Unsigned ADD/INC: RES = zero-extended (N+1)-bit sum; COUT = bit N.
  - SUB/DEC: RES = zero-extended (result mod 2^N); OFLOW=1 on borrow.
  - CMP: RES=0; exactly one of G/E/L is set (unsigned compare).
  - SADD/SSUB: RES = (N+1)-bit signed result sign-extended to 2N; OFLOW = signed overflow of the N-bit result; G/E/L from the signed compare of A and B.
  - Logic ops: result in RES[N-1:0], upper bits 0; COUT and OFLOW are 0.
  - Rotates use the amount OPB[$clog2(N)-1:0]. If any higher OPB bit is set, ERR=1 and the rotated result is still driven.
  - Flags not defined for an op are 0.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: SADD/SSUB saturate to 2^(N-1)−1 or −2^(N-1), sign-extended into RES; OFLOW is still set when saturation occurs.
- Undefined: results wrap as described in Behaviour.

Decomposition:
- Package alu_pkg holds:
  - the CMD encodings for both modes;
  - the FSM state enum;
  - the default TIMEOUT;
  - the error-result constant.
- Sub-module alu_mul2: registered 2-stage N×N→2N multiplier, with a valid-in/valid-out pair.
- Top level holds the FSM, operand/command latches, timeout counter, combinational op core and output registers.

Test Plan:
- ADD at N=8: MODE=1, CMD=0, A=0xFF, B=0x01, INP_VALID=11 → next cycle RES=0x0100, COUT=1, RES_VALID high for 1 cycle, BUSY low afterwards.
- Split operands: cycle 0 INP_VALID=01, A=0x05, CMD=1; cycle 3 INP_VALID=10, B=0x07 → cycle 4 RES=0x00FE, OFLOW=1; BUSY high in cycles 1–4.
- Timeout: INP_VALID=01 with CMD=0, then 00 for 16 cycles → ERR=1, RES=0, single RES_VALID pulse, FSM back in IDLE.
- MUL_INC: A=3, B=4, INP_VALID=11 → RES=0x0014 two cycles later. CE=0 for 2 cycles mid-op delays RES_VALID by exactly 2.
- ROL: MODE=0, CMD=12, A=0x81, B=0x09 → RES=0x0003, ERR=1. With B=0x01 → RES=0x0003, ERR=0.
- Reset in WAIT_B: assert RST asynchronously between edges → all outputs 0 and BUSY 0 immediately. A subsequent ADD 1+1 gives RES=0x0002.
